// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_pc_unit_if #(
    parameter int unsigned BITS = 63
);
    logic            imem_req;
    logic [BITS:0]   imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch stage (FETCH/HOLD).
// Optional FETCH_MISALIGN_CHK_EN blocks PC commits of misaligned addresses.
module fetch_pc_unit #(
    parameter int unsigned     BITS       = 63,
    parameter logic [BITS:0]   RESET_ADDR = '0,
    parameter int unsigned     CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BITS:0]      next_addr,
    input  logic               pc_write,
    output logic [BITS:0]      pc,
    output logic [BITS:0]      pc_plus4,
    fetch_pc_unit_if.master    imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic               misaligned,
`endif
    output logic [CNT_W-1:0]   fetch_count
);

    localparam int unsigned AW = BITS + 1;

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [BITS:0]    pc_nxt;
    logic [31:0]      instr_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] cnt_nxt;
`ifdef FETCH_MISALIGN_CHK_EN
    logic             mis_nxt;
`endif

    // Request is combinational so it drops in the very cycle reset is high.
    assign imem.imem_req  = (state == FETCH) && !reset;
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + AW'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_ADDR;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            misaligned  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fetch_count <= cnt_nxt;
`ifdef FETCH_MISALIGN_CHK_EN
            misaligned  <= mis_nxt;
`endif
        end
    end

    // Next-state logic; pc_write is only honoured once an instruction is held.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        cnt_nxt   = fetch_count;
`ifdef FETCH_MISALIGN_CHK_EN
        mis_nxt   = misaligned;
`endif
        case (state)
            FETCH: begin
                valid_nxt = 1'b0;
                if (imem.imem_ready) begin
                    instr_nxt = imem.imem_rdata;
                    valid_nxt = 1'b1;
                    cnt_nxt   = fetch_count + CNT_W'(1);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                valid_nxt = 1'b1;
                if (pc_write) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    if (next_addr[1:0] != 2'b00) begin
                        mis_nxt = 1'b1;
                    end else begin
                        mis_nxt   = 1'b0;
                        pc_nxt    = next_addr;
                        valid_nxt = 1'b0;
                        state_nxt = FETCH;
                    end
`else
                    pc_nxt    = next_addr;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
`endif
                end
            end
            default: begin
                state_nxt = FETCH;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit against a transaction-level model.
module tb_fetch_pc_unit;

    localparam int unsigned BITS  = 63;
    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [BITS:0]    next_addr;
    logic             pc_write;
    logic [BITS:0]    pc;
    logic [BITS:0]    pc_plus4;
    logic [31:0]      instr;
    logic             instr_valid;
    logic [CNT_W-1:0] fetch_count;
`ifdef FETCH_MISALIGN_CHK_EN
    logic             misaligned;
`endif

    fetch_pc_unit_if #(.BITS(BITS)) bus ();

    fetch_pc_unit #(.BITS(BITS), .RESET_ADDR('0), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .next_addr   (next_addr),
        .pc_write    (pc_write),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
`ifdef FETCH_MISALIGN_CHK_EN
        .misaligned  (misaligned),
`endif
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: "holding" means an instruction for the current pc has been received.
    logic [BITS:0]    m_pc;
    bit               m_holding;
    logic [31:0]      m_instr;
    logic [CNT_W-1:0] m_cnt;
    bit               m_mis;

    // Values observed just before the active edge (combinational outputs).
    logic             pre_req;
    logic [BITS:0]    pre_addr;
    bit               exp_req;
    logic [BITS:0]    exp_addr;

    task automatic drive(input bit rst, input bit rdy, input logic [31:0] rd,
                         input bit pw, input logic [BITS:0] na);
        reset              = rst;
        bus.imem_ready     = rdy;
        bus.imem_rdata     = rd;
        pc_write           = pw;
        next_addr          = na;
        exp_req            = !rst && !m_holding;
        exp_addr           = m_pc;
        #1;
        pre_req            = bus.imem_req;
        pre_addr           = bus.imem_addr;
        if (rst) begin
            m_pc = '0; m_holding = 0; m_instr = '0; m_cnt = '0; m_mis = 0;
        end else if (!m_holding) begin
            if (rdy) begin
                m_holding = 1; m_instr = rd; m_cnt = m_cnt + 1;
            end
        end else if (pw) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (na % 4 != 0) m_mis = 1;
            else begin m_pc = na; m_holding = 0; m_mis = 0; end
`else
            m_pc = na; m_holding = 0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 32'hDEAD_BEEF, 0, '0);
        n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", pre_req); end
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    endtask

    task automatic test_first_fetch();
        drive(0, 1, 32'h0050_0093, 0, '0);
        n_checks++; if (pre_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%0b exp=1", pre_req); end
        n_checks++; if (pre_addr !== '0) begin n_fail++; $display("FAIL first_addr got=%h exp=0", pre_addr); end
        n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL first_instr got=%h exp=00500093", instr); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%0b exp=1", instr_valid); end
        n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL first_count got=%0d exp=1", fetch_count); end
        n_checks++; if (pc_plus4 !== 64'd4) begin n_fail++; $display("FAIL first_pcp4 got=%h exp=4", pc_plus4); end
    endtask

    task automatic test_commit();
        drive(0, 0, 32'h0, 1, 64'h4);
        n_checks++; if (pc !== 64'h4) begin n_fail++; $display("FAIL commit_pc got=%h exp=4", pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL commit_valid got=%0b exp=0", instr_valid); end
        drive(0, 1, 32'h0010_0113, 0, '0);
        n_checks++; if (pre_req !== 1'b1) begin n_fail++; $display("FAIL commit_req got=%0b exp=1", pre_req); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid2 got=%0b exp=1", instr_valid); end
        n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL commit_count got=%0d exp=2", fetch_count); end
        n_checks++; if (instr !== 32'h0010_0113) begin n_fail++; $display("FAIL commit_instr got=%h exp=00100113", instr); end
    endtask

    task automatic test_wait_state();
        drive(0, 0, 32'h0, 1, 64'h8);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, $urandom, (i % 2) == 0, 64'h100);
            n_checks++; if (pre_addr !== 64'h8) begin n_fail++; $display("FAIL wait_addr[%0d] got=%h exp=8", i, pre_addr); end
            n_checks++; if (pre_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d] got=%0b exp=1", i, pre_req); end
            n_checks++; if (pc !== 64'h8) begin n_fail++; $display("FAIL wait_pc[%0d] got=%h exp=8", i, pc); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d] got=%0b exp=0", i, instr_valid); end
        end
        drive(0, 1, 32'hCAFE_0013, 0, '0);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_done_valid got=%0b exp=1", instr_valid); end
        n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL wait_done_count got=%0d exp=3", fetch_count); end
        n_checks++; if (instr !== 32'hCAFE_0013) begin n_fail++; $display("FAIL wait_done_instr got=%h exp=cafe0013", instr); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, $urandom, 0, {$urandom, $urandom});
            n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got=%0b exp=0", i, pre_req); end
            n_checks++; if (instr !== 32'hCAFE_0013) begin n_fail++; $display("FAIL stall_instr[%0d] got=%h exp=cafe0013", i, instr); end
            n_checks++; if (pc !== 64'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got=%h exp=8", i, pc); end
            n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_count[%0d] got=%0d exp=3", i, fetch_count); end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        n_checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h exp=fffffffffffffffc", pc); end
        n_checks++; if (pc_plus4 !== '0) begin n_fail++; $display("FAIL wrap_pcp4 got=%h exp=0", pc_plus4); end
        drive(0, 1, 32'h1111_2222, 0, '0);
        drive(0, 0, 32'h0, 1, '0);
        drive(0, 1, 32'h3333_4444, 0, '0);
        n_checks++; if (pre_addr !== '0) begin n_fail++; $display("FAIL wrap_refetch_addr got=%h exp=0", pre_addr); end
        n_checks++; if (instr !== 32'h3333_4444) begin n_fail++; $display("FAIL wrap_refetch_instr got=%h exp=33334444", instr); end
        n_checks++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL wrap_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_same_addr();
        drive(0, 0, 32'h0, 1, '0);
        drive(0, 1, 32'h5555_6666, 0, '0);
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL same_pc got=%h exp=0", pc); end
        n_checks++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL same_count got=%0d exp=6", fetch_count); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 32'h0, 1, 64'h20);
        drive(1, 1, 32'h7777_8888, 0, '0);
        n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req got=%0b exp=0", pre_req); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr got=%h exp=0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%0b exp=0", instr_valid); end
        n_checks++; if (fetch_count !== '0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", fetch_count); end
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL rstmid_pc got=%h exp=0", pc); end
    endtask

    task automatic test_misalign();
        drive(0, 1, 32'h0000_0013, 0, '0);
        drive(0, 0, 32'h0, 1, 64'h102);
`ifdef FETCH_MISALIGN_CHK_EN
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL mis_pc got=%h exp=0", pc); end
        n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%0b exp=1", misaligned); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid got=%0b exp=1", instr_valid); end
        drive(0, 0, 32'h0, 1, 64'h104);
        n_checks++; if (pc !== 64'h104) begin n_fail++; $display("FAIL mis_clear_pc got=%h exp=104", pc); end
        n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear_flag got=%0b exp=0", misaligned); end
`else
        n_checks++; if (pc !== 64'h102) begin n_fail++; $display("FAIL mis_pc got=%h exp=102", pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid got=%0b exp=0", instr_valid); end
`endif
    endtask

    task automatic test_random();
        logic [BITS:0] na;
        for (int i = 0; i < 400; i++) begin
            na = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) na[1:0] = 2'b00;
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 1) == 1, na);
            n_checks++; if (pre_req !== exp_req) begin n_fail++; $display("FAIL rnd_req[%0d] got=%0b exp=%0b", i, pre_req, exp_req); end
            n_checks++; if (pre_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, pre_addr, exp_addr); end
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
            n_checks++; if (pc_plus4 !== m_pc + 64'd4) begin n_fail++; $display("FAIL rnd_pcp4[%0d] got=%h exp=%h", i, pc_plus4, m_pc + 64'd4); end
            n_checks++; if (instr_valid !== m_holding) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", i, instr_valid, m_holding); end
            n_checks++; if (instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, instr, m_instr); end
            n_checks++; if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, fetch_count, m_cnt); end
`ifdef FETCH_MISALIGN_CHK_EN
            n_checks++; if (misaligned !== m_mis) begin n_fail++; $display("FAIL rnd_mis[%0d] got=%0b exp=%0b", i, misaligned, m_mis); end
`endif
        end
    endtask

    initial begin
        m_pc = '0; m_holding = 0; m_instr = '0; m_cnt = '0; m_mis = 0;
        reset = 1'b1; pc_write = 1'b0; next_addr = '0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0;
        test_reset();
        test_first_fetch();
        test_commit();
        test_wait_state();
        test_stall();
        test_wrap();
        test_same_addr();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
